// File: rtl/blur_window_sched.sv
// Sequencer for a 3x3 (1-2-1 separable) weighted blur: issues neighbour reads, drives the
// external MAC and divider, then writes each output pixel in raster order.
module blur_window_sched #(
  parameter int WIDTH  = 960,
  parameter int HEIGHT = 539,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [2:0]        mac_weight,
  output logic              div_start,
  output logic [4:0]        div_value,
  input  logic              div_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_TAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DIV   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO       = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

  function automatic logic [1:0] tap_row(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      default:          tap_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      default:          tap_col = 2'd2;
    endcase
  endfunction

  function automatic logic [2:0] tap_weight(input logic [1:0] ki, input logic [1:0] kj);
    case ({ki == 2'd1, kj == 2'd1})
      2'b11:        tap_weight = 3'd4;
      2'b10, 2'b01: tap_weight = 3'd2;
      default:      tap_weight = 3'd1;
    endcase
  endfunction

  // Taps stepping off the frame edge are skipped rather than clamped or wrapped.
  function automatic logic tap_in_bounds(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col,
                                         input logic [1:0] ki, input logic [1:0] kj);
    logic row_ok;
    logic col_ok;
    row_ok = !((ki == 2'd0 && row == ZERO) || (ki == 2'd2 && row == LAST_ROW));
    col_ok = !((kj == 2'd0 && col == ZERO) || (kj == 2'd2 && col == LAST_COL));
    tap_in_bounds = row_ok && col_ok;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [3:0]        tap_q, tap_d;
  logic [4:0]        wsum_q, wsum_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic              mac_clr_q, mac_clr_d, mac_en_q, mac_en_d, div_start_q, div_start_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [2:0]        mac_weight_q, mac_weight_d;
  logic [4:0]        div_value_q, div_value_d;
  logic [1:0]        cur_ki, cur_kj, nxt_ki, nxt_kj;
  logic [2:0]        cur_w;
  logic              cur_inb, nxt_inb;
  logic [ADDR_W-1:0] nxt_row, nxt_col;

  // Decode the tap addressed by the current cycle's read.
  always_comb begin
    cur_ki  = tap_row(tap_q);
    cur_kj  = tap_col(tap_q);
    cur_w   = tap_weight(cur_ki, cur_kj);
    cur_inb = tap_in_bounds(i_q, j_q, cur_ki, cur_kj);
  end

  // Next-state and pixel/tap counter logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    tap_d   = tap_q;
    wsum_d  = wsum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          i_d     = ZERO;
          j_d     = ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        wsum_d  = 5'd0;
        tap_d   = 4'd0;
        state_d = S_TAP;
      end
      S_TAP: begin
        if (cur_inb) begin
          wsum_d = wsum_q + {2'b00, cur_w};
        end else begin
          wsum_d = wsum_q;
        end
        if (tap_q == 4'd8) begin
          tap_d   = 4'd0;
          state_d = S_DRAIN;
        end else begin
          tap_d   = tap_q + 4'd1;
          state_d = S_TAP;
        end
      end
      S_DRAIN: state_d = S_DIV;
      // div_start_q marks the launch cycle, whose div_done is stale from a previous op.
      S_DIV: begin
        if (!div_start_q && div_done) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_WRITE: begin
        if (!wr_ready) begin
          state_d = S_WRITE;
        end else if (j_q == LAST_COL && i_q == LAST_ROW) begin
          i_d     = ZERO;
          j_d     = ZERO;
          state_d = S_DONE;
        end else if (j_q == LAST_COL) begin
          i_d     = i_q + ONE;
          j_d     = ZERO;
          state_d = S_CLEAR;
        end else begin
          j_d     = j_q + ONE;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they belong to.
  always_comb begin
    nxt_ki       = tap_row(tap_d);
    nxt_kj       = tap_col(tap_d);
    nxt_inb      = tap_in_bounds(i_q, j_q, nxt_ki, nxt_kj);
    nxt_row      = i_q + ADDR_W'(nxt_ki) - ONE;
    nxt_col      = j_q + ADDR_W'(nxt_kj) - ONE;
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    mac_clr_d    = (state_d == S_CLEAR);
    rd_en_d      = (state_d == S_TAP) && nxt_inb;
    mac_en_d     = rd_en_q;
    div_start_d  = (state_q == S_DRAIN);
    wr_en_d      = (state_d == S_WRITE);
    if (rd_en_d) begin
      rd_addr_d = nxt_row * ROW_STRIDE + nxt_col;
    end else begin
      rd_addr_d = ZERO;
    end
    if (rd_en_q) begin
      mac_weight_d = cur_w;
    end else begin
      mac_weight_d = 3'd0;
    end
    if (state_q == S_DRAIN) begin
      div_value_d = wsum_q;
    end else if (state_d == S_DIV) begin
      div_value_d = div_value_q;
    end else begin
      div_value_d = 5'd0;
    end
    if (wr_en_d) begin
      wr_addr_d = i_q * ROW_STRIDE + j_q;
    end else begin
      wr_addr_d = ZERO;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      i_q          <= ZERO;
      j_q          <= ZERO;
      tap_q        <= 4'd0;
      wsum_q       <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= ZERO;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_weight_q <= 3'd0;
      div_start_q  <= 1'b0;
      div_value_q  <= 5'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= ZERO;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      tap_q        <= tap_d;
      wsum_q       <= wsum_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      mac_clr_q    <= mac_clr_d;
      mac_en_q     <= mac_en_d;
      mac_weight_q <= mac_weight_d;
      div_start_q  <= div_start_d;
      div_value_q  <= div_value_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign mac_clr    = mac_clr_q;
  assign mac_en     = mac_en_q;
  assign mac_weight = mac_weight_q;
  assign div_start  = div_start_q;
  assign div_value  = div_value_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;

endmodule

// File: tb/tb_blur_window_sched.sv
// Self-checking bench for blur_window_sched on a 4x3 frame: a neighbourhood model with random
// divider/write stalls, a table of known pixels, and reset/restart sequences.
module tb_blur_window_sched;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 6;
  localparam int P  = W * H;

  logic          clk, rst_n, start, div_done, wr_ready;
  logic          busy, done, rd_en, mac_clr, mac_en, div_start, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0]    mac_weight;
  logic [4:0]    div_value;
  logic [26:0]   outs;

  assign outs = {busy, done, rd_en, rd_addr, mac_clr, mac_en, mac_weight,
                 div_start, div_value, wr_en, wr_addr};

  blur_window_sched #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_weight(mac_weight), .div_start(div_start), .div_value(div_value),
    .div_done(div_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr[$];
  int exp_wt[$];
  int exp_tap[$];
  int exp_sum;
  int obs_addr[P][9];
  int obs_wt[P][9];
  int obs_n[P];
  int obs_div[P];
  int obs_wr[P];

  typedef struct packed {
    logic [3:0]  pix;
    logic [3:0]  n;
    logic [35:0] addrs;  // read k in nibble k
    logic [26:0] wts;    // weight k in octal digit k
    logic [4:0]  dv;
    logic [3:0]  wa;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected reads of pixel p, straight from the kernel definition.
  task automatic load_model(input int p);
    int i, j, ni, nj, w;
    i = p / W;
    j = p % W;
    exp_addr.delete();
    exp_wt.delete();
    exp_tap.delete();
    exp_sum = 0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        ni = i + di;
        nj = j + dj;
        w  = (di == 0 ? 2 : 1) * (dj == 0 ? 2 : 1);
        if (ni >= 0 && ni < H && nj >= 0 && nj < W) begin
          exp_addr.push_back(ni * W + nj);
          exp_wt.push_back(w);
          exp_tap.push_back((di + 1) * 3 + (dj + 1));
          exp_sum += w;
        end
      end
    end
  endtask

  // div_fix: 0 = random divider latency, else fixed; wr_fix: -1 = random write stall, else fixed.
  task automatic run_frame(input int div_fix, input int wr_fix, input bit chk_time, input int extra_cyc);
    int cyc, p, pix_start, n_divst, div_cnt, wr_cnt, seen_done, pend_wt, held_div, held_wr, a, w, t;
    bit waiting_div, in_write, first_w, acc_pend, prev_rd, armed;
    p = 0; pix_start = 0; n_divst = 0; div_cnt = 0; wr_cnt = 0; seen_done = 0; pend_wt = 0;
    held_div = 0; held_wr = 0; waiting_div = 0; in_write = 0; first_w = 0; acc_pend = 0;
    prev_rd = 0; armed = 0;
    for (int k = 0; k < P; k++) begin
      obs_n[k] = 0; obs_div[k] = -1; obs_wr[k] = -1;
    end
    load_model(0);
    div_done = 1'b0;
    wr_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    check("start_busy", int'(busy), 1);
    check("start_mac_clr", int'(mac_clr), 1);
    while (seen_done == 0 && cyc < 3000) begin
      if (acc_pend) begin
        acc_pend = 0; in_write = 0; wr_ready = 1'b0; div_done = 1'b0;
        check("div_start_count", n_divst, 1);
        n_divst = 0;
        p++;
        if (p < P) load_model(p);
      end
      if (prev_rd) begin
        check("mac_en", int'(mac_en), 1);
        check("mac_weight", int'(mac_weight), pend_wt);
        if (p < P && obs_n[p] > 0) obs_wt[p][obs_n[p]-1] = int'(mac_weight);
      end else begin
        check("mac_en_idle", int'(mac_en), 0);
      end
      if (mac_clr) pix_start = cyc;
      prev_rd = rd_en;
      if (rd_en) begin
        check("rd_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) begin
          a = exp_addr.pop_front();
          w = exp_wt.pop_front();
          t = exp_tap.pop_front();
          check("rd_addr", int'(rd_addr), a);
          check("rd_slot", cyc - pix_start, t + 1);
          pend_wt = w;
          if (p < P && obs_n[p] < 9) begin
            obs_addr[p][obs_n[p]] = int'(rd_addr);
            obs_n[p]++;
          end
        end
      end
      if (div_start) begin
        n_divst++;
        check("div_reads_done", exp_addr.size(), 0);
        check("div_value", int'(div_value), exp_sum);
        if (p < P) obs_div[p] = int'(div_value);
        held_div = int'(div_value);
        waiting_div = 1; armed = 0;
        div_cnt = (div_fix > 0) ? div_fix : int'($urandom_range(1, 4));
        div_done = ($urandom_range(0, 1) == 1);  // must be ignored on the launch cycle
      end else if (waiting_div) begin
        check("wr_en_timing", int'(wr_en), int'(armed));
        if (wr_en) begin
          waiting_div = 0; in_write = 1; first_w = 1;
          held_wr = int'(wr_addr);
          check("wr_addr", int'(wr_addr), p);
          if (p < P) obs_wr[p] = int'(wr_addr);
          wr_cnt = (wr_fix >= 0) ? wr_fix : int'($urandom_range(0, 5));
        end else begin
          check("div_value_hold", int'(div_value), held_div);
          if (div_cnt > 0) div_cnt--;
          armed = (div_cnt == 0);
          div_done = armed;
        end
      end else if (!in_write) begin
        check("wr_en_idle", int'(wr_en), 0);
      end
      if (in_write) begin
        if (!first_w) begin
          check("wr_en_hold", int'(wr_en), 1);
          check("wr_addr_hold", int'(wr_addr), held_wr);
        end
        first_w = 0;
        if (wr_cnt > 0) begin
          wr_cnt--;
          wr_ready = 1'b0;
        end else begin
          wr_ready = 1'b1;
          acc_pend = 1;
        end
      end
      if (done) begin
        seen_done++;
        check("done_after_last", p, P);
        check("done_busy", int'(busy), 0);
        if (chk_time) check("done_cycle", cyc, 14 * P + 1);
      end else begin
        check("busy", int'(busy), 1);
      end
      start = (cyc == extra_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("done_single_pulse", int'({done, busy}), 0);
  endtask

  initial begin
    int resume_exp[4];
    int resume_got[$];
    rst_n = 1'b0; start = 1'b0; div_done = 1'b0; wr_ready = 1'b0;
    tbl[0] = '{4'd0,  4'd4, 36'h000005410, 27'o000001224, 5'd9,  4'd0};
    tbl[1] = '{4'd5,  4'd9, 36'hA98654210, 27'o121242121, 5'd16, 4'd5};
    tbl[2] = '{4'd1,  4'd6, 36'h000654210, 27'o000121242, 5'd12, 4'd1};
    tbl[3] = '{4'd4,  4'd6, 36'h000985410, 27'o000122412, 5'd12, 4'd4};
    tbl[4] = '{4'd11, 4'd4, 36'h00000BA76, 27'o000004221, 5'd9,  4'd11};
    resume_exp = '{0, 1, 4, 5};

    repeat (2) @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_outputs", int'(outs), 0);
    end

    run_frame(1, 0, 1'b1, 50);
    for (int v = 0; v < 5; v++) begin
      int vp, vn;
      vp = int'(tbl[v].pix);
      vn = int'(tbl[v].n);
      check("tbl_nreads", obs_n[vp], vn);
      for (int k = 0; k < vn; k++) begin
        check("tbl_rd_addr", obs_addr[vp][k], int'(tbl[v].addrs[k*4 +: 4]));
        check("tbl_mac_weight", obs_wt[vp][k], int'(tbl[v].wts[k*3 +: 3]));
      end
      check("tbl_div_value", obs_div[vp], int'(tbl[v].dv));
      check("tbl_wr_addr", obs_wr[vp], int'(tbl[v].wa));
    end

    run_frame(3, 5, 1'b0, 0);
    run_frame(0, -1, 1'b0, 0);
    run_frame(0, -1, 1'b0, 0);

    // Reset during tap 1 of pixel 6 (row 1, col 2), then restart from pixel 0.
    div_done = 1'b1; wr_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14 * 6 + 2) @(negedge clk);
    check("pre_reset_rd_en", int'(rd_en), 1);
    check("pre_reset_rd_addr", int'(rd_addr), 2);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(outs), 0);
    div_done = 1'b0; wr_ready = 1'b0;
    @(negedge clk);
    check("reset_held_outputs", int'(outs), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", int'(outs), 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && resume_got.size() < 4; c++) begin
      if (rd_en) resume_got.push_back(int'(rd_addr));
      @(negedge clk);
    end
    check("restart_nreads", resume_got.size(), 4);
    for (int k = 0; k < resume_got.size() && k < 4; k++) begin
      check("restart_rd_addr", resume_got[k], resume_exp[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
